// File: rtl/npu_pkg.sv
// Shared NPM definitions: FSM encoding, AXI field constants, page size.
package npu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP,
        ST_DONE
    } npm_state_e;

    localparam logic [2:0] AXI_SIZE_4B    = 3'd2;
    localparam logic [1:0] AXI_BURST_INCR = 2'd1;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'd0;

    localparam int unsigned PAGE_BYTES = 4096;
    localparam int unsigned PAGE_WORDS = PAGE_BYTES / 4;

    // Words left before the next page boundary, 1..PAGE_WORDS.
    function automatic logic [10:0] page_room(input logic [9:0] off);
        page_room = 11'(PAGE_WORDS) - {1'b0, off};
    endfunction

endpackage

// File: rtl/npm_blen.sv
// NPM burst sizing: min(MAX_BEATS, remaining words, words to page end).
// Purely combinational.
module npm_blen
    import npu_pkg::*;
#(
    parameter int MAX_BEATS = 16
) (
    input  logic [9:0]  page_off,
    input  logic [29:0] wrem,
    output logic [8:0]  beats,
    output logic [7:0]  len
);

    logic [10:0] room;
    logic [8:0]  cap;
    logic [8:0]  lim;

    always_comb begin
        room = page_room(page_off);
        if (room < 11'(MAX_BEATS)) begin
            cap = 9'(room);
        end else begin
            cap = 9'(MAX_BEATS);
        end
        if (wrem < 30'(cap)) begin
            lim = 9'(wrem);
        end else begin
            lim = cap;
        end
        beats = lim;
        len   = 8'(lim - 9'd1);
    end

endmodule

// File: rtl/npm.sv
// NPM: AXI4 master moving a word stream to/from memory in INCR bursts.
// One burst outstanding at a time; bursts never cross a 4 KB page.
module npm
    import npu_pkg::*;
#(
    parameter int MAX_BEATS = 16,
    parameter int AXI_ID    = 0
) (
    input  logic        m_axi_aclk,
    input  logic        m_axi_arstn,

    output logic [11:0] m_axi_awid,
    output logic [31:0] m_axi_awaddr,
    output logic [7:0]  m_axi_awlen,
    output logic [2:0]  m_axi_awsize,
    output logic [1:0]  m_axi_awburst,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,

    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wlast,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,

    input  logic [11:0] m_axi_bid,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,

    output logic [11:0] m_axi_arid,
    output logic [31:0] m_axi_araddr,
    output logic [7:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic [1:0]  m_axi_arburst,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,

    input  logic [11:0] m_axi_rid,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rlast,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,

    input  logic        cmd_stt,
    input  logic        cmd_wr,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_siz,
    output logic        cmd_bsy,
    output logic        cmd_fin,
    output logic        cmd_err,

    output logic [31:0] rd_dat,
    output logic        rd_vld,
    input  logic        rd_rdy,
    input  logic [31:0] wr_dat,
    input  logic        wr_vld,
    output logic        wr_rdy
);

    npm_state_e state_q;
    npm_state_e state_d;

    logic [29:0] adr_q;
    logic [29:0] rem_q;
    logic        wr_q;
    logic        err_q;
    logic [7:0]  len_q;
    logic [7:0]  beat_q;

    logic [8:0]  blen_beats;
    logic [7:0]  blen_len;

    logic in_idle;
    logic in_addr;
    logic in_resp;
    logic wr_data;
    logic rd_data;
    logic start;
    logic a_hs;
    logic w_hs;
    logic r_hs;
    logic last_beat;
    logic more;
    logic unused_ok;

    npm_blen #(
        .MAX_BEATS(MAX_BEATS)
    ) u_blen (
        .page_off(adr_q[9:0]),
        .wrem    (rem_q),
        .beats   (blen_beats),
        .len     (blen_len)
    );

    assign in_idle   = (state_q == ST_IDLE);
    assign in_addr   = (state_q == ST_ADDR);
    assign in_resp   = (state_q == ST_RESP);
    assign wr_data   = (state_q == ST_DATA) & wr_q;
    assign rd_data   = (state_q == ST_DATA) & ~wr_q;
    assign start     = in_idle & cmd_stt;
    assign a_hs      = in_addr
                     & (wr_q ? m_axi_awready : m_axi_arready);
    assign w_hs      = wr_data & wr_vld & m_axi_wready;
    assign r_hs      = rd_data & m_axi_rvalid & rd_rdy;
    assign last_beat = (beat_q == len_q);
    // rem_q already excludes the burst in flight
    assign more      = (rem_q != '0);
    assign unused_ok = ^{m_axi_bid, m_axi_rid,
                         cmd_adr[1:0], cmd_siz[1:0]};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_stt) begin
                    if (cmd_siz[31:2] == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                if (a_hs) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_hs && last_beat) begin
                    state_d = ST_RESP;
                end else if (r_hs && last_beat) begin
                    state_d = more ? ST_ADDR : ST_DONE;
                end
            end
            ST_RESP: begin
                if (m_axi_bvalid) begin
                    state_d = more ? ST_ADDR : ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_arstn) begin
        if (!m_axi_arstn) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            rem_q   <= '0;
            wr_q    <= 1'b0;
            len_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                adr_q <= cmd_adr[31:2];
                rem_q <= cmd_siz[31:2];
                wr_q  <= cmd_wr;
            end
            if (a_hs) begin
                len_q  <= blen_len;
                beat_q <= '0;
                adr_q  <= adr_q + 30'(blen_beats);
                rem_q  <= rem_q - 30'(blen_beats);
            end
            if (w_hs || r_hs) begin
                beat_q <= beat_q + 8'd1;
            end
        end
    end

    // Errors are recorded but never stop the transfer.
    always_ff @(posedge m_axi_aclk or negedge m_axi_arstn) begin
        if (!m_axi_arstn) begin
            err_q <= 1'b0;
        end else if (start) begin
            err_q <= 1'b0;
        end else if ((in_resp && m_axi_bvalid
                      && m_axi_bresp != AXI_RESP_OKAY)
                  || (r_hs && (m_axi_rresp != AXI_RESP_OKAY
                      || m_axi_rlast != last_beat))) begin
            err_q <= 1'b1;
        end
    end

    assign m_axi_awid    = 12'(AXI_ID);
    assign m_axi_arid    = 12'(AXI_ID);
    assign m_axi_awsize  = AXI_SIZE_4B;
    assign m_axi_arsize  = AXI_SIZE_4B;
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_wstrb   = 4'hF;

    assign m_axi_awvalid = in_addr & wr_q;
    assign m_axi_arvalid = in_addr & ~wr_q;
    assign m_axi_awaddr  = m_axi_awvalid ? {adr_q, 2'b00} : '0;
    assign m_axi_araddr  = m_axi_arvalid ? {adr_q, 2'b00} : '0;
    assign m_axi_awlen   = m_axi_awvalid ? blen_len : '0;
    assign m_axi_arlen   = m_axi_arvalid ? blen_len : '0;

    assign m_axi_wvalid  = wr_data & wr_vld;
    assign m_axi_wdata   = wr_data ? wr_dat : '0;
    assign m_axi_wlast   = wr_data & last_beat;
    assign wr_rdy        = wr_data & m_axi_wready;
    assign m_axi_bready  = in_resp;

    assign m_axi_rready  = rd_data & rd_rdy;
    assign rd_vld        = rd_data & m_axi_rvalid;
    assign rd_dat        = rd_data ? m_axi_rdata : '0;

    assign cmd_bsy = (state_q == ST_ADDR)
                   | (state_q == ST_DATA)
                   | in_resp;
    assign cmd_fin = (state_q == ST_DONE);
    assign cmd_err = err_q;

endmodule

// File: tb/tb_npm.sv
// Randomized bench for npm: AXI slave + stream model, scoreboarded
// against burst plans derived from the command alone.
module tb_npm;

    localparam int MB = 16;
    localparam int ID = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
    logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_rdata;
    logic [7:0]  m_axi_awlen, m_axi_arlen;
    logic [2:0]  m_axi_awsize, m_axi_arsize;
    logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
    logic        m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic        cmd_stt, cmd_wr, cmd_bsy, cmd_fin, cmd_err;
    logic [31:0] cmd_adr, cmd_siz, rd_dat, wr_dat;
    logic        rd_vld, rd_rdy, wr_vld, wr_rdy;

    npm #(.MAX_BEATS(MB), .AXI_ID(ID)) dut (
        .m_axi_aclk(clk), .m_axi_arstn(rst_n),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr),
        .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
        .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .cmd_stt(cmd_stt), .cmd_wr(cmd_wr), .cmd_adr(cmd_adr),
        .cmd_siz(cmd_siz), .cmd_bsy(cmd_bsy), .cmd_fin(cmd_fin),
        .cmd_err(cmd_err),
        .rd_dat(rd_dat), .rd_vld(rd_vld), .rd_rdy(rd_rdy),
        .wr_dat(wr_dat), .wr_vld(wr_vld), .wr_rdy(wr_rdy)
    );

    typedef struct {
        logic [31:0] a;
        int          len;
    } burst_t;

    burst_t exp_q[$];
    burst_t log_q[$];

    int total = 0;
    int bad = 0;

    int cmd_no = 0;
    bit wr_cmd, in_cmd, stt_now, tog, err_exp;
    logic [31:0] base;
    int nwords, words_done, fin_cnt, last_cyc;
    bit b_act, b_wr, r_pend;
    logic [31:0] b_addr;
    int b_len, b_beat, cur_idx, bad_idx, bad_kind;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] wr_word(input int k);
        return {16'(cmd_no), 16'(k)} ^ 32'h3C0000C3;
    endfunction

    // Split the command into bursts: no more than MB beats, no
    // more than what is left, never past a 4 KB page end.
    task automatic plan();
        logic [31:0] a;
        int n, room, b;
        a = base;
        n = nwords;
        while (n > 0) begin
            room = (4096 - int'(a % 4096)) / 4;
            b = n;
            if (b > MB) b = MB;
            if (b > room) b = room;
            exp_q.push_back('{a, b - 1});
            a = a + 32'(4 * b);
            n = n - b;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        cmd_stt = stt_now;
        if (!stt_now) begin
            cmd_stt = in_cmd && ($urandom_range(0, 5) == 0);
            cmd_wr  = 1'($urandom_range(0, 1));
            cmd_adr = $urandom;
            cmd_siz = $urandom;
        end
        m_axi_awready = 1'($urandom_range(0, 1));
        m_axi_arready = 1'($urandom_range(0, 1));
        m_axi_wready  = 1'($urandom_range(0, 1));
        wr_vld = 1'($urandom_range(0, 1));
        wr_dat = wr_word(words_done);
        rd_rdy = tog ? ~rd_rdy : 1'($urandom_range(0, 1));
        if (b_act && !b_wr && $urandom_range(0, 3) != 0) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = rd_word(b_addr + 32'(4 * b_beat));
            m_axi_rlast  = (b_beat == b_len);
            m_axi_rresp  = 2'd0;
            if (cur_idx == bad_idx && bad_kind == 1)
                m_axi_rresp = 2'd2;
            if (cur_idx == bad_idx && bad_kind == 2 && b_beat == b_len)
                m_axi_rlast = 1'b0;
        end else begin
            m_axi_rvalid = 1'b0;
            m_axi_rdata  = $urandom;
            m_axi_rlast  = 1'($urandom_range(0, 1));
            m_axi_rresp  = 2'd0;
        end
        m_axi_bvalid = r_pend && ($urandom_range(0, 1) == 1);
        m_axi_bresp  = (cur_idx == bad_idx && bad_kind == 1) ? 2'd2 : 2'd0;
        #1;
        chk("wr_rdy", 64'(wr_rdy),
            64'((b_act && b_wr) ? m_axi_wready : 1'b0));
        chk("wvalid", 64'(m_axi_wvalid),
            64'((b_act && b_wr) ? wr_vld : 1'b0));
        chk("rd_vld", 64'(rd_vld),
            64'((b_act && !b_wr) ? m_axi_rvalid : 1'b0));
        chk("rready", 64'(m_axi_rready),
            64'((b_act && !b_wr) ? rd_rdy : 1'b0));
        chk("bready", 64'(m_axi_bready), 64'(r_pend));
        if (m_axi_awvalid || m_axi_arvalid) begin
            chk("a_legal",
                64'({m_axi_awvalid, m_axi_arvalid, b_act, r_pend,
                     exp_q.size() != 0}),
                64'({wr_cmd, !wr_cmd, 1'b0, 1'b0, 1'b1}));
            if (exp_q.size() != 0) begin
                chk("a_addr", 64'(wr_cmd ? m_axi_awaddr : m_axi_araddr),
                    64'(exp_q[0].a));
                chk("a_len", 64'(wr_cmd ? m_axi_awlen : m_axi_arlen),
                    64'(exp_q[0].len));
                chk("a_const",
                    64'({m_axi_awid, m_axi_awsize, m_axi_awburst,
                         m_axi_arid, m_axi_arsize, m_axi_arburst}),
                    64'({12'(ID), 3'd2, 2'd1, 12'(ID), 3'd2, 2'd1}));
                if (wr_cmd ? m_axi_awready : m_axi_arready) begin
                    b_addr = wr_cmd ? m_axi_awaddr : m_axi_araddr;
                    b_len  = int'(wr_cmd ? m_axi_awlen : m_axi_arlen);
                    log_q.push_back('{b_addr, b_len});
                    void'(exp_q.pop_front());
                    b_act = 1'b1;
                    b_wr = wr_cmd;
                    b_beat = 0;
                    cur_idx++;
                end
            end
        end
        if (b_act && b_wr && m_axi_wvalid && m_axi_wready) begin
            chk("wdata", 64'(m_axi_wdata), 64'(wr_word(words_done)));
            chk("wlast", 64'({m_axi_wlast, m_axi_wstrb}),
                64'({b_beat == b_len, 4'hF}));
            words_done++;
            b_beat++;
            if (b_beat > b_len) begin
                b_act = 1'b0;
                r_pend = 1'b1;
            end
        end else if (b_act && !b_wr && m_axi_rvalid && m_axi_rready) begin
            chk("rd_dat", 64'(rd_dat),
                64'(rd_word(base + 32'(4 * words_done))));
            words_done++;
            b_beat++;
            if (b_beat > b_len) b_act = 1'b0;
        end
        if (r_pend && m_axi_bvalid && m_axi_bready) r_pend = 1'b0;
        if (cmd_fin) begin
            chk("fin_in_cmd", 64'(in_cmd), 64'(1));
            chk("fin_state",
                64'({cmd_bsy, b_act, r_pend, exp_q.size() == 0}),
                64'(4'b0001));
            chk("fin_words", 64'(words_done), 64'(nwords));
            chk("fin_err", 64'(cmd_err), 64'(err_exp));
            fin_cnt++;
            in_cmd = 1'b0;
        end
    endtask

    task automatic start_cmd(input bit w, input logic [31:0] adr,
                             input logic [31:0] siz, input int bidx,
                             input int bkind, input bit tg);
        cmd_no++;
        wr_cmd = w;
        base = adr & ~32'h3;
        nwords = int'(siz >> 2);
        exp_q.delete();
        log_q.delete();
        plan();
        bad_idx = bidx;
        bad_kind = bkind;
        tog = tg;
        cur_idx = -1;
        words_done = 0;
        err_exp = (bkind != 0) && (bidx >= 0) && (bidx < exp_q.size())
                  && !(bkind == 2 && w);
        cmd_wr = w;
        cmd_adr = adr;
        cmd_siz = siz;
        stt_now = 1'b1;
        in_cmd = 1'b1;
        cycle();
        stt_now = 1'b0;
    endtask

    task automatic run_cmd(input bit w, input logic [31:0] adr,
                           input logic [31:0] siz, input int bidx,
                           input int bkind, input bit tg);
        int cyc;
        int fin0;
        fin0 = fin_cnt;
        start_cmd(w, adr, siz, bidx, bkind, tg);
        cyc = 0;
        while (in_cmd && cyc < 4000) begin
            cycle();
            cyc++;
            if (cyc == 1 && nwords > 0)
                chk("bsy_err_start", 64'({cmd_bsy, cmd_err}), 64'(2'b10));
        end
        last_cyc = cyc;
        chk("done_in_time", 64'(in_cmd), 64'(0));
        cycle();
        cycle();
        chk("one_fin", 64'(fin_cnt - fin0), 64'(1));
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ctl"},
            64'({m_axi_awvalid, m_axi_arvalid, m_axi_wvalid, m_axi_wlast,
                 wr_rdy, rd_vld, m_axi_bready, m_axi_rready,
                 cmd_bsy, cmd_fin, cmd_err}), 64'(0));
        chk({nm, "_adr"}, {m_axi_awaddr, m_axi_araddr}, 64'(0));
        chk({nm, "_len"}, 64'({m_axi_awlen, m_axi_arlen}), 64'(0));
        chk({nm, "_dat"}, {m_axi_wdata, rd_dat}, 64'(0));
    endtask

    initial begin
        int n;
        cmd_stt = 0; cmd_wr = 0; cmd_adr = 0; cmd_siz = 0;
        m_axi_awready = 0; m_axi_arready = 0; m_axi_wready = 0;
        m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_bid = 12'(ID);
        m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
        m_axi_rlast = 0; m_axi_rid = 12'(ID);
        rd_rdy = 0; wr_vld = 0; wr_dat = 0;
        in_cmd = 0; stt_now = 0; tog = 0; err_exp = 0;
        b_act = 0; b_wr = 0; r_pend = 0; b_addr = 0;
        b_len = 0; b_beat = 0; cur_idx = -1; bad_idx = -1; bad_kind = 0;
        words_done = 0; nwords = 0; fin_cnt = 0; base = 0; wr_cmd = 0;
        repeat (3) @(negedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        cycle();

        run_cmd(1, 32'h1000, 128, -1, 0, 0);
        chk("w128_nb", 64'(log_q.size()), 64'(2));
        chk("w128_b0", {log_q[0].a, 32'(log_q[0].len)}, {32'h1000, 32'd15});
        chk("w128_b1", {log_q[1].a, 32'(log_q[1].len)}, {32'h1040, 32'd15});
        chk("w128_beats", 64'(words_done), 64'(32));

        run_cmd(0, 32'h0FF8, 16, -1, 0, 0);
        chk("rpg_nb", 64'(log_q.size()), 64'(2));
        chk("rpg_b0", {log_q[0].a, 32'(log_q[0].len)}, {32'h0FF8, 32'd1});
        chk("rpg_b1", {log_q[1].a, 32'(log_q[1].len)}, {32'h1000, 32'd1});

        run_cmd(0, 32'h2000, 12, -1, 0, 1);
        chk("rtog_nb", 64'(log_q.size()), 64'(1));
        chk("rtog_len", 64'(log_q[0].len), 64'(2));
        chk("rtog_beats", 64'(words_done), 64'(3));

        run_cmd(1, 32'h1000, 128, 0, 1, 0);
        chk("berr_nb", 64'(log_q.size()), 64'(2));
        chk("berr_sticky", 64'(cmd_err), 64'(1));

        run_cmd(0, 32'h0500, 0, -1, 0, 0);
        chk("zero_lat", 64'(last_cyc <= 3), 64'(1));
        chk("zero_nb", 64'(log_q.size()), 64'(0));
        chk("err_cleared", 64'(cmd_err), 64'(0));

        run_cmd(0, 32'h0F00, 300, 3, 2, 0);
        chk("rlast_err", 64'(cmd_err), 64'(1));

        start_cmd(1, 32'h4000, 256, -1, 0, 0);
        n = 0;
        while (words_done < 3 && n < 2000) begin
            cycle();
            n++;
        end
        chk("mid_data", 64'({b_act, b_wr}), 64'(2'b11));
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        exp_q.delete();
        b_act = 0; r_pend = 0; in_cmd = 0; words_done = 0;
        cycle();
        cycle();
        chk_zero("rst_hold");
        rst_n = 1'b1;
        run_cmd(0, 32'h3000, 40, -1, 0, 0);
        chk("after_rst_nb", 64'(log_q.size()), 64'(1));
        chk("after_rst_b0",
            {log_q[0].a, 32'(log_q[0].len)}, {32'h3000, 32'd9});

        for (int i = 0; i < 25; i++) begin
            run_cmd(1'($urandom_range(0, 1)),
                    32'h0E00 + 32'($urandom_range(0, 1024)),
                    32'($urandom_range(0, 700)),
                    $urandom_range(0, 3), $urandom_range(0, 2),
                    1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
